inv_mix_column_engine: RTL

Column-serial AES InvMixColumns engine for the decryption datapath. It accepts one 32-bit state column and issues its four bytes in turn on a shared lookup address bus to the four GF(2^8) multiply ROMs (x9, x11, x13, x14). Each ROM has one-cycle registered read latency and outputs 0x00 when not enabled. The engine XOR-accumulates the returned products into the four output bytes, then signals completion with a one-cycle Done pulse.

---
 rtl/inv_mix_column_engine_if.sv | 55 +++++
 rtl/inv_mix_column_engine.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_column_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : inv_mix_column_engine_if
//  Description : Bus bundle between the InvMixColumns engine and its client
//                and the four GF(2^8) multiply ROMs.
//                  Start / Data_In            : column request (client -> engine)
//                  Mul_Read_Enable/_Address   : shared ROM lookup (engine -> ROMs)
//                  Mul9/11/13/14_Data         : ROM products (ROMs -> engine)
//                  Data_Out / Busy / Done     : result and status (engine -> client)
//                Modport slave is the engine; modport master is the
//                environment (client plus ROMs).
//  Revision    : 1.0  initial release
// ============================================================================
interface inv_mix_column_engine_if;
    logic        Start;
    logic [31:0] Data_In;
    logic        Mul_Read_Enable;
    logic [7:0]  Mul_Read_Address;
    logic [7:0]  Mul9_Data;
    logic [7:0]  Mul11_Data;
    logic [7:0]  Mul13_Data;
    logic [7:0]  Mul14_Data;
    logic [31:0] Data_Out;
    logic        Busy;
    logic        Done;

    modport slave (
        input  Start,
        input  Data_In,
        input  Mul9_Data,
        input  Mul11_Data,
        input  Mul13_Data,
        input  Mul14_Data,
        output Mul_Read_Enable,
        output Mul_Read_Address,
        output Data_Out,
        output Busy,
        output Done
    );

    modport master (
        output Start,
        output Data_In,
        output Mul9_Data,
        output Mul11_Data,
        output Mul13_Data,
        output Mul14_Data,
        input  Mul_Read_Enable,
        input  Mul_Read_Address,
        input  Data_Out,
        input  Busy,
        input  Done
    );
endinterface
`default_nettype wire

// File: rtl/inv_mix_column_engine.sv
`default_nettype none
// ============================================================================
//  Module      : inv_mix_column_engine
//  Description : Column-serial AES InvMixColumns engine. One 32-bit column is
//                latched on an accepted Start; its bytes a0..a3 are issued
//                one per cycle on a shared address bus to the x9/x11/x13/x14
//                multiply ROMs (one-cycle registered latency), and the
//                returned products are XOR-accumulated into b0..b3. Data_Out
//                is loaded once, together with a one-cycle Done pulse.
//  Ports       : CLK  - system clock, rising edge
//                RST  - asynchronous active-high reset
//                bus  - inv_mix_column_engine_if.slave (Start, Data_In,
//                       Mul_Read_Enable, Mul_Read_Address, Mul*_Data,
//                       Data_Out, Busy, Done)
//  Options     : INV_MIX_INTERNAL_GF_EN - when defined, products are formed
//                internally with xtime chains; the ROM bus is tied off and
//                the ROM data inputs are ignored. Timing is unchanged.
//  Revision    : 1.0  initial release
// ============================================================================
module inv_mix_column_engine (
    input  wire logic                    CLK,
    input  wire logic                    RST,
    inv_mix_column_engine_if.slave       bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  r_idx;        // byte currently presented on the address bus
    logic [31:0] r_col;        // latched input column
    logic        r_en;         // address bus carries a valid byte this cycle
    logic [7:0]  r_addr;       // byte currently presented
    logic        r_pv;         // product data for byte r_pidx is arriving now
    logic [1:0]  r_pidx;
    logic [31:0] r_acc;        // {b0,b1,b2,b3} partial sums
    logic [31:0] r_data_out;
    logic        r_busy;
    logic        r_done;

    logic        w_start_ok;
    logic [1:0]  w_idx_next;
    logic [7:0]  w_m9;
    logic [7:0]  w_m11;
    logic [7:0]  w_m13;
    logic [7:0]  w_m14;
    logic [31:0] w_contrib;
    logic [31:0] w_acc_next;

    function automatic logic [7:0] col_byte(input logic [31:0] col, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = col[31:24];
            2'd1:    b = col[23:16];
            2'd2:    b = col[15:8];
            default: b = col[7:0];
        endcase
        return b;
    endfunction

    assign w_start_ok = bus.Start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_idx_next = r_idx + 2'd1;

`ifdef INV_MIX_INTERNAL_GF_EN
    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Registered copy of the issued byte stands in for the ROM's read
    // register, so products appear exactly when ROM data would.
    logic [7:0] r_gf_byte;
    logic [7:0] w_x2;
    logic [7:0] w_x4;
    logic [7:0] w_x8;
    logic       w_unused_rom;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_gf_byte <= 8'h00;
        end else begin
            r_gf_byte <= r_en ? r_addr : 8'h00;
        end
    end

    assign w_x2  = xtime(r_gf_byte);
    assign w_x4  = xtime(w_x2);
    assign w_x8  = xtime(w_x4);
    assign w_m9  = w_x8 ^ r_gf_byte;
    assign w_m11 = w_x8 ^ w_x2 ^ r_gf_byte;
    assign w_m13 = w_x8 ^ w_x4 ^ r_gf_byte;
    assign w_m14 = w_x8 ^ w_x4 ^ w_x2;

    assign w_unused_rom = ^{bus.Mul9_Data, bus.Mul11_Data, bus.Mul13_Data, bus.Mul14_Data};

    assign bus.Mul_Read_Enable  = 1'b0;
    assign bus.Mul_Read_Address = 8'h00;
`else
    assign w_m9  = bus.Mul9_Data;
    assign w_m11 = bus.Mul11_Data;
    assign w_m13 = bus.Mul13_Data;
    assign w_m14 = bus.Mul14_Data;

    assign bus.Mul_Read_Enable  = r_en;
    assign bus.Mul_Read_Address = r_addr;
`endif

    // Products of byte a[j] are routed to b0..b3 using column j of the
    // inverse matrix rows {14,11,13,9}, {9,14,11,13}, {13,9,14,11}, {11,13,9,14}.
    always_comb begin
        w_contrib = 32'h0;
        case (r_pidx)
            2'd0:    w_contrib = {w_m14, w_m9,  w_m13, w_m11};
            2'd1:    w_contrib = {w_m11, w_m14, w_m9,  w_m13};
            2'd2:    w_contrib = {w_m13, w_m11, w_m14, w_m9 };
            default: w_contrib = {w_m9,  w_m13, w_m11, w_m14};
        endcase
    end

    assign w_acc_next = r_pv ? (r_acc ^ w_contrib) : r_acc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_col      <= 32'h0;
            r_en       <= 1'b0;
            r_addr     <= 8'h00;
            r_pv       <= 1'b0;
            r_pidx     <= 2'd0;
            r_acc      <= 32'h0;
            r_data_out <= 32'h0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // ROM data for the byte presented now arrives next cycle.
            r_pv   <= r_en;
            r_pidx <= r_idx;
            r_acc  <= w_acc_next;
            r_done <= 1'b0;

            case (r_state)
                S_ISSUE: begin
                    if (r_idx == 2'd3) begin
                        r_state <= S_WAIT;
                        r_en    <= 1'b0;
                        r_addr  <= 8'h00;
                    end else begin
                        r_idx   <= w_idx_next;
                        r_addr  <= col_byte(r_col, w_idx_next);
                    end
                end
                S_WAIT: begin
                    // The last product lands on this edge; publish the
                    // completed column only now so partial sums never show.
                    r_state    <= S_DONE;
                    r_data_out <= w_acc_next;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_idx      <= 2'd0;
                end
                default: begin
                    // S_IDLE and S_DONE both accept a new column.
                    if (w_start_ok) begin
                        r_state <= S_ISSUE;
                        r_col   <= bus.Data_In;
                        r_idx   <= 2'd0;
                        r_en    <= 1'b1;
                        r_addr  <= bus.Data_In[31:24];
                        r_acc   <= 32'h0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.Data_Out = r_data_out;
    assign bus.Busy     = r_busy;
    assign bus.Done     = r_done;

endmodule
`default_nettype wire
